// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: detects EX-stage mispredicts, waits for the
// delay slot to enter the pipe, issues a one-cycle fetch redirect, and queues
// every accepted resolution as a predictor update.

package branch_redirect_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } branch_resolved_t;
endpackage

module branch_redirect_ctrl
  import branch_redirect_pkg::*;
#(
  parameter int unsigned UPD_DEPTH  = 4,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  branch_resolved_t      i_resolved_branch,
  input  logic [31:0]           i_branch_pc,
  input  logic                  i_pred_taken,
  input  logic [31:0]           i_pred_target,
  input  logic                  i_ds_valid,
  input  logic                  i_stall,
  input  logic                  i_except_flush,
  output logic                  o_redirect_valid,
  output logic [31:0]           o_redirect_pc,
  output logic                  o_flush_if,
  output logic                  o_bp_upd_valid,
  input  logic                  i_bp_upd_ready,
  output logic [31:0]           o_bp_upd_pc,
  output logic                  o_bp_upd_taken,
  output logic [31:0]           o_bp_upd_target,
  output logic                  o_busy,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int unsigned AW = $clog2(UPD_DEPTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_DS  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [31:0]           r_redirect_pc;
  logic [31:0]           w_redirect_pc_next;

  logic [31:0]           r_mem_pc     [UPD_DEPTH];
  logic                  r_mem_taken  [UPD_DEPTH];
  logic [31:0]           r_mem_target [UPD_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_accept;
  logic                  w_mispredict;
  logic [31:0]           w_correct_pc;
  logic                  w_redirect;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // Resolution acceptance, mispredict detection and the architecturally correct PC
  always_comb begin
    w_accept     = i_resolved_branch.valid & ~i_stall & ~i_except_flush & (r_state == ST_IDLE);
    w_mispredict = w_accept &
                   ((i_resolved_branch.taken != i_pred_taken) |
                    (i_resolved_branch.taken & (i_resolved_branch.target != i_pred_target)));
    // Not-taken falls through past the delay slot; carry out is discarded
    w_correct_pc = i_resolved_branch.taken ? i_resolved_branch.target : (i_branch_pc + 32'd8);
  end

  // Next-state logic; an exception flush overrides everything and drops the latched PC
  always_comb begin
    w_state_next       = r_state;
    w_redirect_pc_next = r_redirect_pc;
    if (i_except_flush) begin
      w_state_next       = ST_IDLE;
      w_redirect_pc_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mispredict) begin
            w_redirect_pc_next = w_correct_pc;
            w_state_next       = i_ds_valid ? ST_REDIRECT : ST_WAIT_DS;
          end
        end
        ST_WAIT_DS: begin
          if (i_ds_valid) w_state_next = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and latched redirect target
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_next;
      r_redirect_pc <= w_redirect_pc_next;
    end
  end

  // Redirect outputs; the flush suppresses a redirect in the same cycle
  always_comb begin
    w_redirect       = (r_state == ST_REDIRECT) & ~i_except_flush;
    o_redirect_valid = w_redirect;
    o_flush_if       = w_redirect;
    o_redirect_pc    = w_redirect ? r_redirect_pc : '0;
    o_busy           = (r_state == ST_WAIT_DS) | (r_state == ST_REDIRECT);
  end

  // FIFO status and handshake decode; a full FIFO still accepts a push if it pops too
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = ~w_empty & i_bp_upd_ready;
    w_push  = w_accept & (~w_full | w_pop);
    w_drop  = w_accept & w_full & ~w_pop;
  end

  // FIFO storage; contents need no reset because the payload is gated by empty
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem_pc[r_wr_ptr[AW-1:0]]     <= i_branch_pc;
      r_mem_taken[r_wr_ptr[AW-1:0]]  <= i_resolved_branch.taken;
      r_mem_target[r_wr_ptr[AW-1:0]] <= i_resolved_branch.target;
    end
  end

  // FIFO pointers and saturating drop counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Head-of-FIFO payload, forced to zero while empty
  always_comb begin
    o_bp_upd_valid  = ~w_empty;
    o_bp_upd_pc     = w_empty ? '0   : r_mem_pc[r_rd_ptr[AW-1:0]];
    o_bp_upd_taken  = w_empty ? 1'b0 : r_mem_taken[r_rd_ptr[AW-1:0]];
    o_bp_upd_target = w_empty ? '0   : r_mem_target[r_rd_ptr[AW-1:0]];
    o_drop_cnt      = r_drop_cnt;
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized and directed bench for branch_redirect_ctrl against a
// queue-based behavioural model of redirect timing and the update FIFO.

module tb_branch_redirect_ctrl;
  import branch_redirect_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  branch_resolved_t rb;
  logic [31:0]      branch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ds_valid;
  logic             stall;
  logic             except_flush;
  logic             bp_upd_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             bp_upd_valid;
  logic [31:0]      bp_upd_pc;
  logic             bp_upd_taken;
  logic [31:0]      bp_upd_target;
  logic             busy;
  logic [7:0]       drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending-for-delay-slot flag, redirect-this-cycle flag, latched PC, update queue
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;
  upd_t        m_q[$];
  bit          m_wait;
  bit          m_fire;
  logic [31:0] m_pc;
  int          m_drop;

  branch_redirect_ctrl #(.UPD_DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_resolved_branch (rb),
    .i_branch_pc       (branch_pc),
    .i_pred_taken      (pred_taken),
    .i_pred_target     (pred_target),
    .i_ds_valid        (ds_valid),
    .i_stall           (stall),
    .i_except_flush    (except_flush),
    .o_redirect_valid  (redirect_valid),
    .o_redirect_pc     (redirect_pc),
    .o_flush_if        (flush_if),
    .o_bp_upd_valid    (bp_upd_valid),
    .i_bp_upd_ready    (bp_upd_ready),
    .o_bp_upd_pc       (bp_upd_pc),
    .o_bp_upd_taken    (bp_upd_taken),
    .o_bp_upd_target   (bp_upd_target),
    .o_busy            (busy),
    .o_drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic fire;
    fire = m_fire && !except_flush;
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, fire});
    check("flush_if", {31'd0, flush_if}, {31'd0, fire});
    check("redirect_pc", redirect_pc, fire ? m_pc : 32'd0);
    check("busy", {31'd0, busy}, {31'd0, (m_wait || m_fire)});
    check("bp_upd_valid", {31'd0, bp_upd_valid}, {31'd0, (m_q.size() > 0)});
    check("bp_upd_pc", bp_upd_pc, (m_q.size() > 0) ? m_q[0].pc : 32'd0);
    check("bp_upd_taken", {31'd0, bp_upd_taken}, {31'd0, (m_q.size() > 0) ? m_q[0].taken : 1'b0});
    check("bp_upd_target", bp_upd_target, (m_q.size() > 0) ? m_q[0].target : 32'd0);
    check("drop_cnt", {24'd0, drop_cnt}, m_drop);
  endtask

  task automatic model_update();
    bit   accept;
    bit   mis;
    upd_t e;
    if (rst) begin
      m_q.delete();
      m_wait = 0;
      m_fire = 0;
      m_pc   = '0;
      m_drop = 0;
      return;
    end
    accept = rb.valid && !stall && !except_flush && !m_wait && !m_fire;
    mis    = accept && ((rb.taken != pred_taken) || (rb.taken && rb.target != pred_target));
    if (m_q.size() > 0 && bp_upd_ready) void'(m_q.pop_front());
    if (accept) begin
      if (m_q.size() < DEPTH) begin
        e.pc = branch_pc; e.taken = rb.taken; e.target = rb.target;
        m_q.push_back(e);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    if (except_flush) begin
      m_wait = 0; m_fire = 0; m_pc = '0;
    end else if (m_fire) begin
      m_fire = 0;
    end else if (m_wait) begin
      if (ds_valid) begin m_wait = 0; m_fire = 1; end
    end else if (mis) begin
      m_pc = rb.taken ? rb.target : branch_pc + 32'd8;
      if (ds_valid) m_fire = 1; else m_wait = 1;
    end
  endtask

  // One cycle: check current outputs mid-cycle, advance model, land 1 time unit past the edge
  task automatic step();
    #3;
    if (!rst) check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt, input logic ds);
    rb.valid = v; rb.taken = t; rb.target = tgt;
    branch_pc = pc; pred_taken = pt; pred_target = ptgt; ds_valid = ds;
  endtask

  task automatic idle();
    br(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; except_flush = 1'b0; bp_upd_ready = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bp_upd_valid", {31'd0, bp_upd_valid}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Taken mispredict with delay slot present: redirect next cycle
    br(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1);
    step();
    idle();
    check("d34_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("d34_redirect_pc", redirect_pc, 32'h2000);
    check("d34_flush_if", {31'd0, flush_if}, 32'd1);
    check("d34_head_pc", bp_upd_pc, 32'h1000);
    check("d34_head_target", bp_upd_target, 32'h2000);
    bp_upd_ready = 1'b1;
    step();
    step();

    // Not-taken mispredict at top of address space, delay slot arrives late
    bp_upd_ready = 1'b0;
    br(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    step();
    idle();
    step();
    step();
    ds_valid = 1'b1;
    step();
    ds_valid = 1'b0;
    check("d35_redirect_pc", redirect_pc, 32'h0000_0004);
    check("d35_busy", {31'd0, busy}, 32'd1);
    step();

    // Correct prediction: no redirect, one update queued
    br(1'b1, 32'h500, 1'b1, 32'h3000, 1'b1, 32'h3000, 1'b0);
    step();
    idle();
    check("d36_busy", {31'd0, busy}, 32'd0);
    step();

    // Flush while waiting for the delay slot cancels the redirect
    br(1'b1, 32'h600, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    except_flush = 1'b1;
    step();
    except_flush = 1'b0;
    ds_valid = 1'b1;
    step();
    check("d37_no_redirect", {31'd0, redirect_valid}, 32'd0);
    idle();
    step();

    // Full FIFO with ready low: six pushes keep four and drop two
    do_reset();
    bp_upd_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      br(1'b1, 32'h100 * i, 1'b1, 32'h8000 + i, 1'b1, 32'h8000 + i, 1'b0);
      step();
    end
    idle();
    check("d38_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    check("d38_head_pc", bp_upd_pc, 32'h100);
    bp_upd_ready = 1'b1;
    br(1'b1, 32'h700, 1'b1, 32'h8007, 1'b1, 32'h8007, 1'b0);
    step();
    idle();
    bp_upd_ready = 1'b0;
    check("d38_pushpop_drop", {24'd0, drop_cnt}, 32'd2);
    check("d38_pushpop_head", bp_upd_pc, 32'h200);
    bp_upd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Stalled resolution is ignored
    stall = 1'b1;
    br(1'b1, 32'h900, 1'b1, 32'h9000, 1'b0, 32'h0, 1'b1);
    step();
    stall = 1'b0;
    idle();
    check("d39_busy", {31'd0, busy}, 32'd0);
    check("d39_bp_upd_valid", {31'd0, bp_upd_valid}, 32'd0);
    step();

    // Randomized traffic; small target set so predictions often match
    for (int c = 0; c < 3000; c++) begin
      rb.valid     = ($urandom_range(0, 99) < 55);
      rb.taken     = $urandom_range(0, 1) == 1;
      rb.target    = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
      branch_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 1)) * 4
                                                  : $urandom;
      pred_taken   = ($urandom_range(0, 99) < 70) ? rb.taken : ~rb.taken;
      pred_target  = ($urandom_range(0, 99) < 70) ? rb.target
                                                  : 32'h4000 + 32'($urandom_range(0, 3)) * 4;
      ds_valid     = ($urandom_range(0, 99) < 40);
      stall        = ($urandom_range(0, 99) < 15);
      except_flush = ($urandom_range(0, 99) < 5);
      bp_upd_ready = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 99) < 40);
      rst          = ($urandom_range(0, 999) < 8);
      step();
    end
    rst = 1'b0;
    except_flush = 1'b0;
    stall = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
